// File: rtl/wb_rr_arbiter_if.sv
// ============================================================================
// Module      : wb_rr_arbiter_if
// Description : Wishbone B4 classic bundle shared by the masters, the
//               round-robin arbiter and the downstream slave port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    m_cyc;
  logic [NUM_MASTERS-1:0]    m_stb;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [32*NUM_MASTERS-1:0] m_adr;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [4*NUM_MASTERS-1:0]  m_sel;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_err;

  logic                      s_cyc;
  logic                      s_stb;
  logic                      s_we;
  logic [31:0]               s_adr;
  logic [31:0]               s_dat_i;
  logic [3:0]                s_sel;
  logic [31:0]               s_dat_o;
  logic                      s_ack;
  logic                      s_err;

  logic [NUM_MASTERS-1:0]    grant;

  // Arbiter view: accepts the master requests, drives the slave segment.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_i, m_sel,
    input  s_dat_o, s_ack, s_err,
    output m_dat_o, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_i, s_sel,
    output grant
  );

  // Environment view: the masters and the slave device around the arbiter.
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_i, m_sel,
    output s_dat_o, s_ack, s_err,
    input  m_dat_o, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_i, s_sel,
    input  grant
  );
endinterface

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin Wishbone B4 classic arbiter, grant held for the
//               whole CYC, with a per-transfer watchdog that returns ERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_rr_arbiter_if.slave    bus
);

  localparam int c_idx_w = $clog2(NUM_MASTERS);
  localparam logic [TMO_W-1:0] c_tmo_last =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [c_idx_w-1:0]     r_gidx,  w_gidx_nxt;
  logic [c_idx_w-1:0]     r_last,  w_last_nxt;
  logic [TMO_W-1:0]       r_tmo_cnt;

  logic                   w_active;
  logic                   w_s_cyc;
  logic                   w_s_stb;
  logic                   w_xfer;
  logic                   w_stall;
  logic                   w_tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= c_idx_w'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|bus.m_cyc) begin
          // Descending scan so the nearest requester after r_last wins.
          for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (bus.m_cyc[(int'(r_last) + k) % NUM_MASTERS]) begin
              w_gidx_nxt = c_idx_w'((int'(r_last) + k) % NUM_MASTERS);
            end
          end
          w_grant_nxt             = '0;
          w_grant_nxt[w_gidx_nxt] = 1'b1;
          w_state_nxt             = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!bus.m_cyc[r_gidx]) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_active = |r_grant;

  // Everything toward the slave is forced low unless a grant is held.
  always_comb begin
    w_s_cyc     = 1'b0;
    w_s_stb     = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_i = '0;
    bus.s_sel   = '0;
    if (w_active) begin
      w_s_cyc     = bus.m_cyc[r_gidx];
      w_s_stb     = bus.m_stb[r_gidx];
      bus.s_we    = bus.m_we[r_gidx];
      bus.s_adr   = bus.m_adr[32*int'(r_gidx) +: 32];
      bus.s_dat_i = bus.m_dat_i[32*int'(r_gidx) +: 32];
      bus.s_sel   = bus.m_sel[4*int'(r_gidx) +: 4];
    end
  end

  assign bus.s_cyc = w_s_cyc;
  assign bus.s_stb = w_s_stb;

  assign w_xfer    = w_s_cyc & w_s_stb;
  assign w_stall   = w_xfer & ~bus.s_ack & ~bus.s_err;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_stall && (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_stall || w_tmo_hit || (TIMEOUT_CYCLES == 0) ||
                 (w_grant_nxt != r_grant)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus.m_dat_o = bus.s_dat_o;
  assign bus.m_ack   = r_grant & {NUM_MASTERS{bus.s_ack & w_xfer}};
  assign bus.m_err   = r_grant & {NUM_MASTERS{(bus.s_err | w_tmo_hit) & w_xfer}};
  assign bus.grant   = r_grant;

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 classic slave port among NUM_MASTERS masters. Sits between UVM-driven or RTL masters and a single slave/interconnect segment.
- Holds grant for the whole bus cycle (CYC high), so multi-beat cycles are never split.
- Includes a per-transfer watchdog that terminates hung strobes with ERR.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT_CYCLES, 256, cycles of unacknowledged STB before the arbiter returns ERR; 0 disables the watchdog
- TMO_W, 16, width of the watchdog counter; TIMEOUT_CYCLES < 2**TMO_W

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- m_cyc  input  NUM_MASTERS  per-master CYC
- m_stb  input  NUM_MASTERS  per-master STB
- m_we  input  NUM_MASTERS  per-master WE
- m_adr  input  32*NUM_MASTERS  packed addresses, master i at [32i+31:32i]
- m_dat_i  input  32*NUM_MASTERS  packed write data (master to slave)
- m_sel  input  4*NUM_MASTERS  packed byte selects
- m_dat_o  output  32  read data broadcast to all masters
- m_ack  output  NUM_MASTERS  per-master ACK
- m_err  output  NUM_MASTERS  per-master ERR
- s_cyc  output  1  slave CYC
- s_stb  output  1  slave STB
- s_we  output  1  slave WE
- s_adr  output  32  slave address
- s_dat_i  output  32  write data to slave
- s_sel  output  4  slave byte selects
- s_dat_o  input  32  read data from slave
- s_ack  input  1  slave ACK
- s_err  input  1  slave ERR
- grant  output  NUM_MASTERS  one-hot registered grant, all zero when idle

Behaviour:
- Reset (async, rst_n low):
  - grant=0; state=IDLE; last=NUM_MASTERS-1, so master 0 has first priority; watchdog count=0.
  - All slave outputs are 0 and m_ack/m_err are 0 immediately, because they are gated by grant.
  - Reset mid-cycle abandons the transfer with no ACK/ERR.
- States:
  - IDLE: if any m_cyc is high, select the first requester scanning last+1, last+2, ... (mod NUM_MASTERS). Register grant, go to BUSY. This gives 1 cycle of arbitration latency from CYC to s_cyc.
  - BUSY: combinational mux of granted master's cyc/stb/we/adr/dat_i/sel to s_*. Stay while m_cyc[g]=1. When m_cyc[g]=0, clear grant, set last=g, go to IDLE.
  - Every grant change therefore passes through one idle cycle, with s_cyc=0 in that cycle.
- Ungranted masters see m_ack=0 and m_err=0; their STB is ignored until granted.
- m_dat_o = s_dat_o at all times.
- m_ack[g] = s_ack & s_cyc & s_stb.
- m_err[g] = (s_err | tmo_hit) & s_cyc & s_stb. A slave ACK/ERR while STB is low is dropped.
- Watchdog:
  - Counts cycles with s_cyc & s_stb & !s_ack & !s_err.
  - Clears on ACK, ERR, STB low or grant change.
  - tmo_hit is asserted when count == TIMEOUT_CYCLES-1 and the current cycle still has no ACK/ERR; it produces one ERR pulse, then the counter clears.
  - If s_ack and tmo_hit coincide, ACK wins and no ERR is generated.
  - If s_ack and s_err coincide, both pass through and the master treats ERR as dominant.
- Simultaneous requests arriving in the same cycle are resolved strictly by rotation order; there is no fixed priority after the first grant.
- A master dropping m_cyc in the same cycle it is granted still gets a 1-cycle BUSY with s_cyc=0, then IDLE.
- grant is never multi-hot; a bench assertion checks $onehot0(grant).

Test Plan:
- Single master 1 write, adr=0x10, dat=0xDEADBEEF, sel=0xF, slave ACK after 2 cycles -> s_cyc rises 1 cycle after m_cyc[1]; grant=2'b10; m_ack[1] pulses once; m_ack[0]=0.
- Masters 0 and 1 request in the same cycle after reset -> master 0 granted first. After m_cyc[0] drops: 1 idle cycle, then grant=2'b10. Next simultaneous request grants master 0 again.
- Master 0 does a 4-beat read (CYC held, STB per beat) while master 1 requests -> all 4 beats complete under grant 01 before master 1 is granted; s_cyc never deasserts mid-burst.
- Slave never acks, TIMEOUT_CYCLES=8 -> m_err[g] pulses exactly at the 8th stalled cycle; the counter clears; the master drops CYC; grant returns to 0.
- s_ack arriving on the 8th stalled cycle -> m_ack asserted, m_err stays 0.
- rst_n asserted low mid-transfer with grant=01 -> grant, s_cyc, s_stb and m_ack go 0 asynchronously. After release, master 0 is again first priority.
